man_frame_rx: RTL
=================

// Module: man_frame_rx
// PURPOSE
//  Parametrised Manchester frame receiver: oversamples serial line I_CCDL_IN, detects frame header,
//  majority-votes each half-bit, checks Manchester coding and optional parity, outputs one word per frame.
//  Successor of the fixed 6x/16-bit sampler. Adds configurable ratio, width, polarity and parity,
//  error flags, glitch rejection and an abort input. Feeds the downstream decode FIFO.
// PARAMETERS
//  P_OVS        6   clocks per bit; even, >=4 (30 MHz clk / 5 Mbps line = 6)
//  P_DATA_W     16  data bits per frame, 1..32
//  P_PARITY_EN  1   1: one parity bit follows the data bits; 0: no parity bit
//  P_ODD_PAR    1   1: odd parity over data+parity; 0: even parity
//  P_POLARITY   0   0: logic 1 = high-then-low half-bits; 1: logic 1 = low-then-high
//  P_HDR_LEN    7   clocks from detected header rising edge to phase 0 of first data bit
//  P_HDR_MIN    4   min clocks line must stay high in header, else glitch; P_HDR_MIN <= P_HDR_LEN
// PORTS
//  I_sys_clk       in   1         system clock
//  I_rst_n         in   1         asynchronous, active-low reset
//  I_enable        in   1         receiver enable; low aborts any frame in progress
//  I_CCDL_IN       in   1         asynchronous Manchester serial input
//  O_data          out  P_DATA_W  received word, bit 0 = first data bit on the line
//  O_valid         out  1         1-cycle pulse: O_data and error flags are valid
//  O_parity_err    out  1         parity mismatch; meaningful only when O_valid=1
//  O_code_err      out  1         Manchester violation in any bit; meaningful only when O_valid=1
//  O_busy          out  1         1 when FSM is not in IDLE
// BEHAVIOUR
//  Clock and reset: I_sys_clk; reset I_rst_n asynchronous, active-low.
//  Reset values: all outputs 0, FSM=IDLE, all counters and sync flops 0.
//  Input: 2-flop synchroniser then 1 history flop. rise = prev 0 and current 1 on synced data.
//  FSM states:
//   IDLE: on rise with I_enable=1, go to HDR with hdr_cnt=0.
//   HDR: hdr_cnt++ each clock. Synced line 0 while hdr_cnt<P_HDR_MIN: glitch, go to IDLE.
//        At hdr_cnt=P_HDR_LEN-1, go to DATA with phase=0, bit_cnt=0, sums=0, code_err=0.
//   DATA: phase counts 0..P_OVS-1 and wraps. Let H=P_OVS/2.
//        sum_a = count of synced 1s in phases 0..H-1; sum_b = same for phases H..P_OVS-1.
//        At phase P_OVS-1: lvl_a = (2*sum_a > H) and lvl_b = (2*sum_b' > H), where sum_b' includes this sample.
//        lvl_a==lvl_b sets sticky code_err. Decided bit = lvl_a XOR P_POLARITY.
//        Shift register fills LSB-first. Clear sums, bit_cnt++.
//        After bit P_DATA_W+P_PARITY_EN-1, go to DONE.
//   DONE: single cycle. Next clock: O_valid=1, O_data=captured word, O_code_err=code_err,
//        O_parity_err = P_PARITY_EN & (XOR(data,parity) != P_ODD_PAR). Then go to IDLE.
//  Latency: O_valid rises 2 clocks after the last sample of the final bit.
//        O_valid, O_parity_err and O_code_err are high for exactly 1 cycle.
//        O_data holds its value until the next valid frame.
//  Retrigger: IDLE needs a fresh rise. A line already high on entering IDLE does not start a frame.
//  Abort: I_enable=0 in HDR, DATA or DONE forces IDLE next clock. No O_valid, O_data unchanged.
//        If abort and the DONE transition happen in the same cycle, abort wins.
//  Mid-frame reset: all state returns to reset values immediately. No partial word is ever output.
//  Widths: bit_cnt is $clog2(P_DATA_W+2) bits. sum_a/sum_b are $clog2(H+1) bits. No counter wraps beyond its terminal value.
//  O_busy = (state != IDLE); it is combinational from registered state.
// TESTING
//  T1 reset: assert I_rst_n=0 mid-frame -> all outputs 0 at once; after release, next clean frame decodes.
//  T2 nominal (defaults): header then 16'hA5C3 LSB-first with odd parity bit 1 -> one O_valid pulse;
//     O_data=16'hA5C3, both errs 0, pulse 2 clocks after last sample.
//  T3 parity: same frame with parity bit inverted -> O_valid=1, O_data=16'hA5C3, O_parity_err=1, O_code_err=0.
//  T4 code error: bit 5 held high for both halves -> O_valid=1, O_code_err=1.
//     Also: 1 flipped sample per half-bit -> still decodes with no error.
//  T5 glitch/abort: 3-clock high pulse -> stays IDLE, no O_valid. I_enable=0 at bit 8 -> IDLE next clock, no O_valid.
//  T6 params: P_OVS=8, P_DATA_W=32, P_PARITY_EN=0, P_POLARITY=1 with 32'hDEADBEEF
//     -> O_data=32'hDEADBEEF, both errs 0, back-to-back frames both decoded.

Source files
------------

// File: rtl/man_frame_rx_if.sv
// man_frame_rx_if
//   Bundles the serial-side inputs and the word-side outputs of the
//   Manchester frame receiver.
//   Signals:
//     I_enable      receiver enable (low aborts a frame in progress)
//     I_CCDL_IN     asynchronous Manchester serial line
//     O_data        received word, bit 0 = first data bit on the line
//     O_valid       1-cycle strobe qualifying O_data and the error flags
//     O_parity_err  parity mismatch (qualified by O_valid)
//     O_code_err    Manchester violation (qualified by O_valid)
//     O_busy        receiver is inside a frame
//   Modports: master = line driver / word consumer, slave = receiver.
interface man_frame_rx_if #(
  parameter int P_DATA_W = 16
);
  logic                I_enable;
  logic                I_CCDL_IN;
  logic [P_DATA_W-1:0] O_data;
  logic                O_valid;
  logic                O_parity_err;
  logic                O_code_err;
  logic                O_busy;

  modport master (
    output I_enable, I_CCDL_IN,
    input  O_data, O_valid, O_parity_err, O_code_err, O_busy
  );

  modport slave (
    input  I_enable, I_CCDL_IN,
    output O_data, O_valid, O_parity_err, O_code_err, O_busy
  );
endinterface

// File: rtl/man_frame_rx.sv
// man_frame_rx
//   Oversampling Manchester frame receiver. Synchronises the serial line,
//   waits for a header rising edge, rejects short header glitches, then
//   majority-votes both halves of every bit, flags Manchester violations and
//   (optionally) parity errors, and presents one word per frame.
//   Ports:
//     I_sys_clk  system clock
//     I_rst_n    asynchronous active-low reset
//     bus        man_frame_rx_if.slave (enable, serial in, word/flags out)
module man_frame_rx #(
  parameter int P_OVS       = 6,
  parameter int P_DATA_W    = 16,
  parameter int P_PARITY_EN = 1,
  parameter int P_ODD_PAR   = 1,
  parameter int P_POLARITY  = 0,
  parameter int P_HDR_LEN   = 7,
  parameter int P_HDR_MIN   = 4
) (
  input  logic           I_sys_clk,
  input  logic           I_rst_n,
  man_frame_rx_if.slave  bus
);

  localparam int H      = P_OVS / 2;
  localparam int W_TOT  = P_DATA_W + P_PARITY_EN;
  localparam int HC_W   = $clog2(P_HDR_LEN + 1);
  localparam int PH_W   = $clog2(P_OVS);
  localparam int BC_W   = $clog2(P_DATA_W + 2);
  localparam int SUM_W  = $clog2(H + 1);
  localparam logic POL_B = 1'(P_POLARITY);
  localparam logic ODD_B = 1'(P_ODD_PAR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Shift one decided bit in at the top so the first bit ends up in bit 0.
  // The extended temporary keeps this valid for a 1-bit frame as well.
  function automatic logic [W_TOT-1:0] shift_in(input logic [W_TOT-1:0] word, input logic b);
    logic [W_TOT:0] ext;
    ext = {b, word};
    return ext[W_TOT:1];
  endfunction

  // Parity over data and parity bit must equal the configured sense.
  function automatic logic parity_mismatch(input logic [W_TOT-1:0] word);
    return (^word) != ODD_B;
  endfunction

  state_t              state_r, next_state_s;
  logic                sync1_r, sync2_r, prev_r;
  logic                rise_s, en_s;
  logic [HC_W-1:0]     hdr_cnt_r;
  logic [PH_W-1:0]     phase_r;
  logic [BC_W-1:0]     bit_cnt_r;
  logic [SUM_W-1:0]    sum_a_r, sum_b_r, sum_b_full_s;
  logic                lvl_a_s, lvl_b_s, bit_s, last_sample_s;
  logic                code_err_r;
  logic [W_TOT-1:0]    shreg_r;
  logic                start_data_s, sample_s, emit_s;
  logic [P_DATA_W-1:0] data_r;
  logic                valid_r, parity_err_r, code_err_out_r;

  assign en_s          = bus.I_enable;
  assign rise_s        = sync2_r & ~prev_r;
  assign last_sample_s = (phase_r == PH_W'(P_OVS - 1));
  // Second-half vote includes the sample being taken in the last phase.
  assign sum_b_full_s  = sum_b_r + {{(SUM_W-1){1'b0}}, sync2_r};
  assign lvl_a_s       = ({sum_a_r, 1'b0} > (SUM_W+1)'(H));
  assign lvl_b_s       = ({sum_b_full_s, 1'b0} > (SUM_W+1)'(H));
  assign bit_s         = lvl_a_s ^ POL_B;

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= bus.I_CCDL_IN;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; a dropped enable beats every other transition.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s && en_s) next_state_s = ST_HDR;
        else                next_state_s = ST_IDLE;
      end
      ST_HDR: begin
        if (!en_s)                                               next_state_s = ST_IDLE;
        else if (!sync2_r && (hdr_cnt_r < HC_W'(P_HDR_MIN)))     next_state_s = ST_IDLE;
        else if (hdr_cnt_r == HC_W'(P_HDR_LEN - 1))              next_state_s = ST_DATA;
        else                                                     next_state_s = ST_HDR;
      end
      ST_DATA: begin
        if (!en_s)                                                  next_state_s = ST_IDLE;
        else if (last_sample_s && (bit_cnt_r == BC_W'(W_TOT - 1)))  next_state_s = ST_DONE;
        else                                                        next_state_s = ST_DATA;
      end
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes.
  always_comb begin
    start_data_s = 1'b0;
    sample_s     = 1'b0;
    emit_s       = 1'b0;
    case (state_r)
      ST_HDR:  start_data_s = (next_state_s == ST_DATA);
      ST_DATA: sample_s     = en_s;
      ST_DONE: emit_s       = en_s;
      default: begin
        start_data_s = 1'b0;
        sample_s     = 1'b0;
        emit_s       = 1'b0;
      end
    endcase
  end

  // Header length counter; only runs while in HDR.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hdr_cnt_r <= {HC_W{1'b0}};
    end else if (state_r == ST_HDR) begin
      hdr_cnt_r <= hdr_cnt_r + HC_W'(1);
    end else begin
      hdr_cnt_r <= {HC_W{1'b0}};
    end
  end

  // Bit sampler: phase counter, half-bit vote sums, shift register, code error.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      phase_r    <= {PH_W{1'b0}};
      bit_cnt_r  <= {BC_W{1'b0}};
      sum_a_r    <= {SUM_W{1'b0}};
      sum_b_r    <= {SUM_W{1'b0}};
      code_err_r <= 1'b0;
      shreg_r    <= {W_TOT{1'b0}};
    end else if (start_data_s) begin
      phase_r    <= {PH_W{1'b0}};
      bit_cnt_r  <= {BC_W{1'b0}};
      sum_a_r    <= {SUM_W{1'b0}};
      sum_b_r    <= {SUM_W{1'b0}};
      code_err_r <= 1'b0;
    end else if (sample_s) begin
      if (last_sample_s) begin
        phase_r   <= {PH_W{1'b0}};
        sum_a_r   <= {SUM_W{1'b0}};
        sum_b_r   <= {SUM_W{1'b0}};
        bit_cnt_r <= bit_cnt_r + BC_W'(1);
        shreg_r   <= shift_in(shreg_r, bit_s);
        // Equal half levels cannot be a valid Manchester symbol.
        if (lvl_a_s == lvl_b_s) code_err_r <= 1'b1;
        else                    code_err_r <= code_err_r;
      end else begin
        phase_r <= phase_r + PH_W'(1);
        if (phase_r < PH_W'(H)) sum_a_r <= sum_a_r + {{(SUM_W-1){1'b0}}, sync2_r};
        else                    sum_b_r <= sum_b_r + {{(SUM_W-1){1'b0}}, sync2_r};
      end
    end else begin
      phase_r <= phase_r;
    end
  end

  // Registered word outputs; strobes last one cycle, O_data holds until the next word.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      data_r         <= {P_DATA_W{1'b0}};
      valid_r        <= 1'b0;
      parity_err_r   <= 1'b0;
      code_err_out_r <= 1'b0;
    end else if (emit_s) begin
      data_r         <= shreg_r[P_DATA_W-1:0];
      valid_r        <= 1'b1;
      parity_err_r   <= (P_PARITY_EN != 0) ? parity_mismatch(shreg_r) : 1'b0;
      code_err_out_r <= code_err_r;
    end else begin
      valid_r        <= 1'b0;
      parity_err_r   <= 1'b0;
      code_err_out_r <= 1'b0;
    end
  end

  assign bus.O_data       = data_r;
  assign bus.O_valid      = valid_r;
  assign bus.O_parity_err = parity_err_r;
  assign bus.O_code_err   = code_err_out_r;
  assign bus.O_busy       = (state_r != ST_IDLE);

endmodule
